// File: rtl/jtkcpu_simresp.sv
// Simulation/bring-up bus responder for the jtkcpu bus: control window at 0x1000-0x100F
// (finish/bad flags, interrupt lines, interval timer) plus wait states for a slow region.
module jtkcpu_simresp #(
  parameter int         WAITS   = 2,
  parameter logic [3:0] SLOW_HI = 4'hF,
  parameter int         TW      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [23:0] addr,
  input  logic [7:0]  wr_data,
  input  logic        we,
  output logic [7:0]  rd_data,
  output logic        sel,
  output logic        busy,
  output logic        nmi_n,
  output logic        firq_n,
  output logic        irq_n,
  output logic        sim_finish,
  output logic        sim_bad
);

  localparam int WCW      = $clog2(WAITS + 2);
  localparam int WINIT    = (WAITS > 0) ? WAITS - 1 : 0;
  localparam bit HAS_WAIT = (WAITS > 0);

  logic          finish_q, finish_d;
  logic          bad_q, bad_d;
  logic [2:0]    level_q, level_d;
  logic [TW-1:0] reload_q, reload_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          auto_q, auto_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [2:0]    pend_q, pend_d;
  logic          nmi_n_q, firq_n_q, irq_n_q;
  logic [15:0]   last_q, last_d;
  logic          first_q, first_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  logic          wr_en;
  logic          wr_ctrl, wr_rlo, wr_rhi, wr_tctrl, wr_stat;
  logic          expire;
  logic [2:0]    pend_set, pend_clr;
  logic [15:0]   reload16, reload16_d, cnt16;
  logic          start, slow_start;

  assign sel      = (addr[15:4] == 12'h100);
  assign wr_en    = sel & we & cen;
  assign wr_ctrl  = wr_en & (addr[3:0] == 4'h0);
  assign wr_rlo   = wr_en & (addr[3:0] == 4'h2);
  assign wr_rhi   = wr_en & (addr[3:0] == 4'h3);
  assign wr_tctrl = wr_en & (addr[3:0] == 4'h4);
  assign wr_stat  = wr_en & (addr[3:0] == 4'h5);

  assign reload16 = 16'(reload_q);
  assign cnt16    = 16'(cnt_q);
  assign expire   = cen & en_q & (cnt_q == '0);

  always_comb begin
    finish_d = finish_q | (wr_ctrl & wr_data[0]);
    bad_d    = wr_ctrl ? wr_data[1]   : bad_q;
    level_d  = wr_ctrl ? wr_data[7:5] : level_q;

    reload16_d = reload16;
    if (wr_rlo) reload16_d[7:0]  = wr_data;
    if (wr_rhi) reload16_d[15:8] = wr_data;
    reload_d = reload16_d[TW-1:0];

    pend_set = 3'b000;
    if (expire) begin
      case (tgt_q)
        2'd1:    pend_set = 3'b001;
        2'd2:    pend_set = 3'b010;
        2'd3:    pend_set = 3'b100;
        default: pend_set = 3'b000;
      endcase
    end
    pend_clr = wr_stat ? wr_data[2:0] : 3'b000;
    // set wins over a coincident clear so an expiry is never lost
    pend_d   = (pend_q & ~pend_clr) | pend_set;

    cnt_d  = cnt_q;
    en_d   = en_q;
    auto_d = auto_q;
    tgt_d  = tgt_q;
    if (cen & en_q) begin
      if (cnt_q != '0)  cnt_d = cnt_q - TW'(1);
      else if (auto_q)  cnt_d = reload_q;
      else              en_d  = 1'b0;
    end
    // a TCTRL write overrides the timer's own EN/AUTO/TGT update
    if (wr_tctrl) begin
      en_d   = wr_data[0];
      auto_d = wr_data[1];
      tgt_d  = wr_data[3:2];
      if (wr_data[0] & ~en_q) cnt_d = reload_q;
    end
  end

  assign start      = cen & (first_q | (addr[15:0] != last_q));
  assign slow_start = HAS_WAIT & start & (addr[15:12] == SLOW_HI) & ~(sel & we);
  assign busy       = rst_n & (slow_start | (wcnt_q != '0));

  always_comb begin
    wcnt_d  = wcnt_q;
    if (start)                      wcnt_d = slow_start ? WCW'(WINIT) : '0;
    else if (cen && wcnt_q != '0)   wcnt_d = wcnt_q - WCW'(1);
    last_d  = cen ? addr[15:0] : last_q;
    first_d = first_q & ~cen;
  end

  always_comb begin
    rd_data = 8'h00;
    if (sel) begin
      case (addr[3:0])
        4'h0:    rd_data = {level_q, 3'b000, bad_q, finish_q};
        4'h1:    rd_data = addr[23:16];
        4'h2:    rd_data = reload16[7:0];
        4'h3:    rd_data = reload16[15:8];
        4'h4:    rd_data = {4'b0000, tgt_q, auto_q, en_q};
        4'h5:    rd_data = {5'b00000, pend_q};
        4'h6:    rd_data = cnt16[7:0];
        4'h7:    rd_data = cnt16[15:8];
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish_q <= 1'b0;
      bad_q    <= 1'b0;
      level_q  <= 3'b000;
      reload_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      tgt_q    <= 2'd0;
      pend_q   <= 3'b000;
      nmi_n_q  <= 1'b1;
      firq_n_q <= 1'b1;
      irq_n_q  <= 1'b1;
      last_q   <= 16'h0000;
      first_q  <= 1'b1;
      wcnt_q   <= '0;
    end else begin
      finish_q <= finish_d;
      bad_q    <= bad_d;
      level_q  <= level_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      // lines follow level/pending one clk later, independent of cen
      nmi_n_q  <= ~(level_q[2] | pend_q[2]);
      firq_n_q <= ~(level_q[1] | pend_q[1]);
      irq_n_q  <= ~(level_q[0] | pend_q[0]);
      last_q   <= last_d;
      first_q  <= first_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign nmi_n      = nmi_n_q;
  assign firq_n     = firq_n_q;
  assign irq_n      = irq_n_q;
  assign sim_finish = finish_q;
  assign sim_bad    = bad_q;

endmodule

// File: doc/jtkcpu_simresp.md
Name: jtkcpu_simresp

Overview:
- Memory-mapped bus responder for the jtkcpu CPU bus in simulation and board-bring-up benches.
- Decodes the control window at 0x1000–0x100F and serves simulation control: finish/bad flags, interrupt line drive and a programmable interrupt timer.
- Generates wait states (busy) for a slow address region.
- The top level muxes rd_data into the CPU din whenever sel is high.

Parameters:
WAITS, 2, cen ticks of busy per new access into the slow region (0 = no wait states)
SLOW_HI, 4'hF, addr[15:12] value that marks the slow region
TW, 16, timer counter width (8..16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  CPU clock enable; all state advances only when cen=1
addr  in  24  CPU address
wr_data  in  8  CPU write data (dout)
we  in  1  CPU write strobe
rd_data  out  8  read data, combinational, 0 when sel=0
sel  out  1  addr[15:4]==12'h100
busy  out  1  wait-state request for the current access
nmi_n  out  1  active-low NMI
firq_n  out  1  active-low FIRQ
irq_n  out  1  active-low IRQ
sim_finish  out  1  sticky finish request
sim_bad  out  1  test-failed flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared
  - sim_finish=0, sim_bad=0, busy=0
  - nmi_n=firq_n=irq_n=1
  - timer disabled, pending=0
- Writes take effect on the posedge clk where sel & we & cen. Reads are combinational.
- Register map, selected by addr[3:0]:
  - 0 CTRL, write: bit0 sets sim_finish (sticky until reset; writing 0 does not clear it); bit1 loads sim_bad; bits7:5 load level {nmi,firq,irq}.
    CTRL read: {level[2:0],3'b0,sim_bad,sim_finish}.
  - 1 read-only: addr[23:16]. Writes are ignored.
  - 2/3 RELOAD lo/hi. Bits above TW are ignored. Reads return the stored value.
  - 4 TCTRL:
    - bit0 EN, bit1 AUTO, bits3:2 TGT (0 none, 1 irq, 2 firq, 3 nmi).
    - A write that takes EN from 0 to 1 loads counter = RELOAD.
    - A write with EN=1 while already enabled does not reload the counter.
  - 5 STATUS: pending[2:0]={nmi,firq,irq}. A write clears each bit written as 1 (write-1-to-clear).
  - 6/7 counter lo/hi, read-only.
  - 8–F: read 0, writes ignored.
- Timer, on each cen while EN=1:
  - If counter != 0: counter decrements.
  - If counter == 0: expiry.
    - pending[TGT] is set (no effect when TGT=0).
    - If AUTO=1, counter reloads from RELOAD; otherwise EN clears.
  - Period = RELOAD+1 cen ticks. RELOAD=0 expires every cen.
  - A RELOAD write mid-count does not affect the running count; it applies at the next load.
- Simultaneous events:
  - An expiry and a STATUS clear of the same bit in the same cycle leave the bit set.
  - A TCTRL write and an expiry in the same cycle: the written TCTRL wins for EN/AUTO/TGT, and the expiry still sets pending.
- Interrupt outputs are registered and update one clk after the cause: line_n = ~(level | pending) per line.
- Wait states:
  - Access start = cen cycle where addr[15:0] differs from the address registered at the previous cen, or the first cen after reset.
  - If the start is in the slow region (addr[15:12]==SLOW_HI) and WAITS>0, busy goes high combinationally in that cycle and stays high for WAITS cen ticks, including the start tick. It falls after the WAITS-th tick.
  - An address change while busy restarts the count.
  - Writes to the control window never assert busy.
- rst_n asserted mid-operation (timer running, busy high): every output returns to its reset value immediately.

Test Plan:
- Reset then write CTRL=8'h02 → sim_bad=1, sim_finish=0. Write 8'h01 → sim_finish=1. Write 8'h00 → sim_finish stays 1 and sim_bad drops to 0.
- Write CTRL=8'hA0 → nmi_n=0, firq_n=1, irq_n=0 one clk after the write. Read CTRL → 8'hA0.
- RELOAD=3, TCTRL=8'h07 (EN, AUTO, TGT irq) → pending[0] set on cen ticks 4, 8, 12 after enable and irq_n=0. Write STATUS=1 coinciding with the tick-8 expiry → bit stays set.
- RELOAD=0, TCTRL=8'h0D (EN, one-shot, nmi) → expiry on the first cen, EN reads 0, nmi_n=0. The counter then stays 0 and raises no further expiry.
- Read addr=24'h5A1001 → rd_data=8'h5A, sel=1. Read 0x100C → 0. Read 0x2000 → sel=0, rd_data=0.
- WAITS=2: access 0xF010 → busy high for exactly 2 cen ticks. Same address on the next cen → no busy. 0xF011 → busy again. Assert rst_n low while busy → busy=0 at once.
